uart_host_bridge: RTL and testbench

- Serial front end for the command/memory block. Converts an 8N1 UART receive line into byte writes on that block's input FIFO port: i_data_valid and i_data, with back-pressure from o_input_full.
- Drains that block's output FIFO port (o_data, o_output_empty, i_data_read) onto the UART transmit line.
- Lets the host issue reset/read/write/CPU-enable commands over a single serial link.
- Sits at the top level between the pins and the command block. No FIFO of its own; buffering lives in the command block's 16-deep FIFOs.

---
 rtl/uart_host_bridge.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_bridge.sv
// UART (8N1, or 8E1 with UART_PARITY_EN) front end for the command/memory block.
// Latency: RX strobe one cycle after the stop-bit sample (~9.7 bit times after start edge); TX pops one cycle after !i_out_empty.
// Backpressure: RX drops bytes while i_input_full and flags overrun; TX waits on i_out_empty and pops once per frame.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_rx / o_tx             serial lines, idle high
//   o_data_valid, o_data    received byte strobe into the command block input FIFO
//   i_input_full            input FIFO full; a byte completing while full is dropped
//   i_out_data, i_out_empty output FIFO head and empty flag
//   o_out_read              one-cycle pop of the output FIFO
//   i_clear_err             clears the sticky error flags (a same-cycle set wins)
//   o_rx_overrun, o_rx_frame_err, o_rx_parity_err (UART_PARITY_EN only)  sticky errors
//
// Build option: define UART_PARITY_EN for even parity on both directions.
module uart_host_bridge #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    input  logic       i_input_full,
    input  logic [7:0] i_out_data,
    input  logic       i_out_empty,
    output logic       o_out_read,
    input  logic       i_clear_err,
    output logic       o_rx_overrun,
    output logic       o_rx_frame_err
`ifdef UART_PARITY_EN
    ,
    output logic       o_rx_parity_err
`endif
);

    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    rx_state_t     r_rx_state;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_data_valid;
    logic [7:0]    r_data;
    logic          r_overrun;
    logic          r_frame_err;
`ifdef UART_PARITY_EN
    logic          r_rx_par_bad;
    logic          r_parity_err;
`endif

    logic w_rxs;
    logic w_rx_tick;
    logic w_stop_tick;
    logic w_byte_ok;
    logic w_deliver;
    logic w_ovr_set;
    logic w_frm_set;

    assign w_rxs       = r_rx_sync;
    assign w_rx_tick   = (r_rx_cnt == FULL_M1);
    assign w_stop_tick = (r_rx_state == RX_STOP) && w_rx_tick;
`ifdef UART_PARITY_EN
    // A parity failure drops the byte; overrun is only reported for bytes that were otherwise good.
    assign w_byte_ok   = w_rxs & ~r_rx_par_bad;
`else
    assign w_byte_ok   = w_rxs;
`endif
    assign w_deliver   = w_stop_tick & w_byte_ok & ~i_input_full;
    assign w_ovr_set   = w_stop_tick & w_byte_ok & i_input_full;
    assign w_frm_set   = w_stop_tick & ~w_rxs;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_data_valid <= 1'b0;
            r_data       <= 8'h00;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_data_valid <= w_deliver;
            if (w_deliver) begin
                r_data <= r_rx_shift;
            end
            // Set has priority over a simultaneous clear.
            r_overrun    <= w_ovr_set | (r_overrun & ~i_clear_err);
            r_frame_err  <= w_frm_set | (r_frame_err & ~i_clear_err);
`ifdef UART_PARITY_EN
            r_parity_err <= (w_stop_tick & r_rx_par_bad) | (r_parity_err & ~i_clear_err);
`endif

            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Re-check the start bit at its midpoint to reject short glitches.
                    if (r_rx_cnt == HALF_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rxs, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_cnt     <= '0;
                        r_rx_par_bad <= w_rxs ^ (^r_rx_shift);
                        r_rx_state   <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= w_rxs ? RX_IDLE : RX_BREAK;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    // Hold off until the line returns high so a break is not seen as new start bits.
                    if (w_rxs) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_data_valid   = r_data_valid;
    assign o_data         = r_data;
    assign o_rx_overrun   = r_overrun;
    assign o_rx_frame_err = r_frame_err;
`ifdef UART_PARITY_EN
    assign o_rx_parity_err = r_parity_err;
`endif

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t     r_tx_state;
    logic          r_tx;
    logic          r_out_read;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
`ifdef UART_PARITY_EN
    logic          r_tx_par;
`endif

    logic w_tx_tick;
    logic w_tx_load;

    assign w_tx_tick = (r_tx_cnt == FULL_M1);
    // Loading at the last stop cycle as well as in idle gives gapless back-to-back frames.
    assign w_tx_load = ~i_out_empty &&
                       ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_tick));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
            r_out_read <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_out_read <= w_tx_load;
            if (w_tx_load) begin
                r_tx_shift <= i_out_data;
`ifdef UART_PARITY_EN
                r_tx_par   <= ^i_out_data;
`endif
                r_tx       <= 1'b0;
                r_tx_cnt   <= '0;
                r_tx_state <= TX_START;
            end else begin
                case (r_tx_state)
                    TX_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    TX_START: begin
                        if (w_tx_tick) begin
                            r_tx_cnt   <= '0;
                            r_tx_bit   <= 3'd0;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_state <= TX_DATA;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (w_tx_tick) begin
                            r_tx_cnt <= '0;
                            r_tx_bit <= r_tx_bit + 3'd1;
                            if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                                r_tx       <= r_tx_par;
                                r_tx_state <= TX_PARITY;
`else
                                r_tx       <= 1'b1;
                                r_tx_state <= TX_STOP;
`endif
                            end else begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
`ifdef UART_PARITY_EN
                    TX_PARITY: begin
                        if (w_tx_tick) begin
                            r_tx_cnt   <= '0;
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
`endif
                    TX_STOP: begin
                        if (w_tx_tick) begin
                            r_tx_cnt   <= '0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign o_tx       = r_tx;
    assign o_out_read = r_out_read;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: random serial traffic against a frame-level reference model.
// Latency: checks RX strobe timing window and exact per-cycle TX waveform.
// Backpressure: models the command block FIFOs with queues (input full, output empty/pop).
`timescale 1ns/1ps
module tb_uart_host_bridge;

    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       i_clk        = 1'b0;
    logic       i_rst_n      = 1'b0;
    logic       i_rx         = 1'b1;
    logic       i_input_full = 1'b0;
    logic [7:0] i_out_data   = 8'h00;
    logic       i_out_empty  = 1'b1;
    logic       i_clear_err  = 1'b0;
    logic       o_tx;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       o_out_read;
    logic       o_rx_overrun;
    logic       o_rx_frame_err;
`ifdef UART_PARITY_EN
    logic       o_rx_parity_err;
`endif

    uart_host_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx           (i_rx),
        .o_tx           (o_tx),
        .o_data_valid   (o_data_valid),
        .o_data         (o_data),
        .i_input_full   (i_input_full),
        .i_out_data     (i_out_data),
        .i_out_empty    (i_out_empty),
        .o_out_read     (o_out_read),
        .i_clear_err    (i_clear_err),
        .o_rx_overrun   (o_rx_overrun),
        .o_rx_frame_err (o_rx_frame_err)
`ifdef UART_PARITY_EN
        ,
        .o_rx_parity_err(o_rx_parity_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Received-byte monitor.
    logic [7:0] rx_got[$];
    int         rx_t[$];
    always @(negedge i_clk) begin
        if (o_data_valid === 1'b1) begin
            rx_got.push_back(o_data);
            rx_t.push_back(cyc);
        end
    end

    // Output FIFO model of the command block.
    logic [7:0] tx_q[$];
    int         n_reads = 0;
    always @(negedge i_clk) begin
        if (o_out_read === 1'b1) begin
            n_reads++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        i_out_empty = (tx_q.size() == 0);
        i_out_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end

    // Expected sticky flags.
    logic exp_ovr = 1'b0;
    logic exp_frm = 1'b0;
`ifdef UART_PARITY_EN
    logic exp_par = 1'b0;
`endif

    // Drive one serial frame; all calls start on a negedge.
    task automatic send_rx(input logic [7:0] b, input logic stop, input logic par_ok, input int gap);
        logic [10:0] bits;
        int          idx;
        bits = {stop, (^b) ^ ~par_ok, b, 1'b0};
        for (int i = 0; i < NBITS; i++) begin
            idx  = (i == NBITS - 1) ? 10 : i;
            i_rx = bits[idx];
            repeat (CPB) @(negedge i_clk);
        end
        i_rx = 1'b1;
        repeat (gap) @(negedge i_clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic par_ok, input logic full);
        int   n0;
        logic deliver;
        n0      = rx_got.size();
        deliver = stop & par_ok & ~full;
        i_input_full = full;
        send_rx(b, stop, par_ok, stop ? 4 : CPB);
        i_input_full = 1'b0;
        if (stop && par_ok && full) exp_ovr = 1'b1;
        if (!stop) exp_frm = 1'b1;
`ifdef UART_PARITY_EN
        if (!par_ok) exp_par = 1'b1;
`endif
        chk("rx_strobe_count", rx_got.size() - n0, {31'd0, deliver});
        if (deliver && rx_got.size() > n0) chk("rx_byte", {24'd0, rx_got[n0]}, {24'd0, b});
        chk("rx_overrun_flag", o_rx_overrun, exp_ovr);
        chk("rx_frame_err_flag", o_rx_frame_err, exp_frm);
`ifdef UART_PARITY_EN
        chk("rx_parity_err_flag", o_rx_parity_err, exp_par);
`endif
    endtask

    task automatic clear_flags();
        i_clear_err = 1'b1;
        @(negedge i_clk);
        i_clear_err = 1'b0;
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
`ifdef UART_PARITY_EN
        exp_par = 1'b0;
`endif
        @(negedge i_clk);
    endtask

    // Wait for a start bit on o_tx and check every cycle of the frame; returns on the last stop cycle.
    task automatic tx_expect(input logic [7:0] b, output int t_start);
        logic [10:0] bits;
        int          n;
        int          s;
        int          idx;
        bits = {1'b1, ^b, b, 1'b0};
        n    = 0;
        while (o_tx !== 1'b0 && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        t_start = cyc;
        chk("tx_start_seen", {31'd0, o_tx === 1'b0}, 32'd1);
        if (o_tx === 1'b0) begin
            for (int i = 0; i < FRAME; i++) begin
                s   = i / CPB;
                idx = (s == NBITS - 1) ? 10 : s;
                chk($sformatf("tx_slot%0d", s), {31'd0, o_tx}, {31'd0, bits[idx]});
                if (i != FRAME - 1) @(negedge i_clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0, n0, r0, lat, t0, t1, lows, n;
        logic seen;

        // Reset values.
        repeat (3) @(negedge i_clk);
        chk("rst_tx", o_tx, 1);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_data", {24'd0, o_data}, 0);
        chk("rst_read", o_out_read, 0);
        chk("rst_overrun", o_rx_overrun, 0);
        chk("rst_frame_err", o_rx_frame_err, 0);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);

        // Single RX byte with latency window.
        c0 = cyc;
        n0 = rx_got.size();
        rx_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        if (rx_got.size() > n0) begin
            lat = rx_t[n0] - c0;
            chk("rx_latency_in_window", {31'd0, (lat >= FRAME - 8) && (lat <= FRAME - 4)}, 32'd1);
        end

        // Single TX byte, then idle.
        r0 = n_reads;
        tx_q.push_back(8'h3C);
        tx_expect(8'h3C, t0);
        lows = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1) lows++;
        end
        chk("tx_single_pop", n_reads - r0, 1);
        chk("tx_idle_high", lows, 0);

        // Overrun, clear, recovery.
        rx_frame(8'h55, 1'b1, 1'b1, 1'b1);
        clear_flags();
        chk("overrun_cleared", o_rx_overrun, 0);
        rx_frame(8'h55, 1'b1, 1'b1, 1'b0);

        // Bad stop bit followed by a held-low line.
        n0 = rx_got.size();
        send_rx(8'h81, 1'b0, 1'b1, 0);
        i_rx = 1'b0;
        repeat (100) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (8) @(negedge i_clk);
        exp_frm = 1'b1;
        chk("break_no_strobe", rx_got.size() - n0, 0);
        chk("break_frame_err", o_rx_frame_err, 1);
        rx_frame(8'h12, 1'b1, 1'b1, 1'b0);

        // Short glitch is ignored, next frame intact.
        clear_flags();
        n0 = rx_got.size();
        i_rx = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (12) @(negedge i_clk);
        chk("glitch_no_strobe", rx_got.size() - n0, 0);
        chk("glitch_no_frame_err", o_rx_frame_err, 0);
        chk("glitch_no_overrun", o_rx_overrun, 0);
        rx_frame(8'hFF, 1'b1, 1'b1, 1'b0);

        // Overrun set coinciding with a held clear: set must be visible for a cycle.
        n0   = rx_got.size();
        seen = 1'b0;
        i_input_full = 1'b1;
        fork
            send_rx(8'h6E, 1'b1, 1'b1, 4);
            begin
                repeat (FRAME - 10) @(negedge i_clk);
                i_clear_err = 1'b1;
                repeat (10) begin
                    @(negedge i_clk);
                    if (o_rx_overrun === 1'b1) seen = 1'b1;
                end
                i_clear_err = 1'b0;
            end
        join
        i_input_full = 1'b0;
        chk("set_beats_clear", {31'd0, seen}, 32'd1);
        chk("clear_after_set", o_rx_overrun, 0);
        chk("set_clear_no_strobe", rx_got.size() - n0, 0);

        // Concurrent random RX and back-to-back TX.
        fork
            begin
                logic [7:0] tb_bytes[6];
                int         tp;
                r0 = n_reads;
                for (int k = 0; k < 6; k++) begin
                    tb_bytes[k] = 8'($urandom);
                    tx_q.push_back(tb_bytes[k]);
                end
                tp = 0;
                for (int k = 0; k < 6; k++) begin
                    tx_expect(tb_bytes[k], t1);
                    if (k > 0) chk("tx_back_to_back_gap", t1 - tp, FRAME);
                    tp = t1;
                end
                chk("tx_random_pops", n_reads - r0, 6);
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    logic [7:0] b;
                    logic       st, po, fu;
                    b  = 8'($urandom);
                    st = ($urandom_range(0, 4) != 0);
                    fu = ($urandom_range(0, 3) == 0);
`ifdef UART_PARITY_EN
                    po = ($urandom_range(0, 4) != 0);
`else
                    po = 1'b1;
`endif
                    rx_frame(b, st, po, fu);
                    if ($urandom_range(0, 2) == 0) clear_flags();
                end
            end
        join

        // Reset mid TX data bit and mid RX frame.
        clear_flags();
        rx_frame(8'h33, 1'b1, 1'b1, 1'b1);
        r0 = n_reads;
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hC3);
        n = 0;
        while (o_tx !== 1'b0 && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        chk("rst_test_tx_started", {31'd0, o_tx === 1'b0}, 32'd1);
        i_rx = 1'b0;
        repeat (CPB * 4 + CPB / 2) @(negedge i_clk);
        chk("pre_reset_tx_bit3_low", o_tx, 0);
        n0 = rx_got.size();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_tx", o_tx, 1);
        chk("midrst_valid", o_data_valid, 0);
        chk("midrst_data", {24'd0, o_data}, 0);
        chk("midrst_read", o_out_read, 0);
        chk("midrst_overrun", o_rx_overrun, 0);
        chk("midrst_frame_err", o_rx_frame_err, 0);
`ifdef UART_PARITY_EN
        chk("midrst_parity_err", o_rx_parity_err, 0);
`endif
        i_rst_n = 1'b1;
        i_rx    = 1'b1;
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
        tx_expect(8'hC3, t1);
        chk("refetch_after_reset", n_reads - r0, 2);
        repeat (FRAME) @(negedge i_clk);
        chk("rx_aborted_by_reset", rx_got.size() - n0, 0);
        chk("post_reset_tx_idle", o_tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
